// File: rtl/ofdm_burst_pkg.sv
// Shared constants and types for the OFDM burst path (time synchronizer and
// symbol streamer).
package ofdm_burst_pkg;

  localparam int FFT_POINT         = 64;
  localparam int CP_NUM            = 16;
  localparam int NUM_DATA_SYM      = 8;
  localparam int NUM_CHEST_SYM     = 4;
  localparam int NUM_SYM           = NUM_CHEST_SYM + NUM_DATA_SYM;
  localparam int SAMPLES_PER_BURST = NUM_SYM * FFT_POINT;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE,
    WAIT_CLR
  } burst_state_e;

  // Tag travelling alongside an outstanding buffer read.
  typedef struct packed {
    logic vld;
    logic last;
    logic user;
  } rd_tag_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Small synchronous FIFO with occupancy count; absorbs read-latency slack
// between the buffer read pipeline and the AXI-Stream output.
module stream_skid_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: every always_comb output is assigned on all paths so no latch is inferred.
  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only observed once count covers it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));

endmodule

// File: rtl/ofdm_symbol_streamer.sv
// Reads a full CP-stripped burst out of the synchronizer buffer and streams
// it per OFDM symbol to the FFT, then releases the buffer with tx_done.
module ofdm_symbol_streamer #(
  parameter int SAMPLE_W   = 8,
  parameter int ADDR_W     = 10,
  parameter int FFT_POINT  = ofdm_burst_pkg::FFT_POINT,
  parameter int NUM_SYM    = ofdm_burst_pkg::NUM_SYM,
  parameter int CHEST_SYM  = ofdm_burst_pkg::NUM_CHEST_SYM,
  parameter int RD_LAT     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       out_buff_full,
  input  logic signed [SAMPLE_W-1:0] din,
  output logic        [ADDR_W-1:0]   read_ptr,
  output logic                       tx_done,
  output logic signed [SAMPLE_W-1:0] m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic                       m_tuser,
  output logic                       busy
);
  import ofdm_burst_pkg::*;

  localparam int TOTAL     = NUM_SYM * FFT_POINT;
  localparam int SYM_SHIFT = $clog2(FFT_POINT);
  localparam int CNT_W     = ADDR_W + 1;
  localparam int FCNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W   = SAMPLE_W + 2;

  burst_state_e              state_q, state_d;
  logic [CNT_W-1:0]          issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]          sent_cnt_q, sent_cnt_d;
  logic [ADDR_W-1:0]         read_ptr_q, read_ptr_d;
  rd_tag_t [RD_LAT-1:0]      infl_q, infl_d;

  logic                      issue, pop, credit_ok, infl_any;
  int                        infl_cnt;
  logic                      fifo_empty, fifo_full;
  logic [FCNT_W-1:0]         fifo_cnt;
  logic [ENTRY_W-1:0]        fifo_rdata;
  rd_tag_t                   cap_tag;

  assign cap_tag  = infl_q[RD_LAT-1];
  assign m_tvalid = !fifo_empty;
  assign pop      = m_tvalid && m_tready;
  assign read_ptr = read_ptr_q;

  // Head is gated so the stream outputs read as zero whenever nothing is valid.
  assign {m_tuser, m_tlast, m_tdata} = m_tvalid ? fifo_rdata : '0;

  // A beat leaving this cycle frees its slot in time for a read issued now,
  // which keeps one sample per cycle with only RD_LAT+1 entries.
  always_comb begin
    infl_cnt = 0;
    for (int i = 0; i < RD_LAT; i++) begin
      infl_cnt = infl_cnt + int'(infl_q[i].vld);
    end
    infl_any  = (infl_cnt != 0);
    credit_ok = (int'(fifo_cnt) - int'(pop) + infl_cnt) < FIFO_DEPTH;
    issue     = (state_q == STREAM) && credit_ok;
  end

  always_comb begin
    infl_d[0] = rd_tag_t'{
      vld:  issue,
      last: (issue_cnt_q[SYM_SHIFT-1:0] == '1),
      user: ((issue_cnt_q >> SYM_SHIFT) < CNT_W'(CHEST_SYM))
    };
    for (int i = 1; i < RD_LAT; i++) begin
      infl_d[i] = infl_q[i-1];
    end
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    sent_cnt_d  = sent_cnt_q;
    read_ptr_d  = read_ptr_q;
    if (state_q == IDLE) begin
      issue_cnt_d = '0;
      sent_cnt_d  = '0;
    end else begin
      if (issue) begin
        read_ptr_d  = issue_cnt_q[ADDR_W-1:0];
        issue_cnt_d = issue_cnt_q + CNT_W'(1);
      end
      if (pop) begin
        sent_cnt_d = sent_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      sent_cnt_q  <= '0;
      read_ptr_q  <= '0;
      infl_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
      read_ptr_q  <= read_ptr_d;
      infl_q      <= infl_d;
    end
  end

  // Dropping out_buff_full mid-burst is ignored; WAIT_CLR stops a stale level
  // from retriggering the same burst.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (out_buff_full) state_d = STREAM;
      STREAM:   if (issue && issue_cnt_q == CNT_W'(TOTAL - 1)) state_d = DRAIN;
      DRAIN:    if (fifo_empty && !infl_any) state_d = DONE;
      DONE:     state_d = WAIT_CLR;
      WAIT_CLR: if (!out_buff_full) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_done = (state_q == DONE);
    busy    = (state_q != IDLE);
  end

  stream_skid_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cap_tag.vld),
    .wdata_i ({cap_tag.user, cap_tag.last, din}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  a_credit: assert property (@(posedge clk) disable iff (!rst_n) !(cap_tag.vld && fifo_full));
  a_all_sent: assert property (@(posedge clk) disable iff (!rst_n)
                               (state_q == DONE) |-> (sent_cnt_q == CNT_W'(TOTAL)));

endmodule

// File: tb/tb_ofdm_symbol_streamer.sv
// Scoreboard bench for ofdm_symbol_streamer with a two-register buffer read
// model behind read_ptr (read_ptr itself is the address register).
module tb_ofdm_symbol_streamer;

  localparam int TOTAL = 768;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              out_buff_full = 1'b0;
  logic signed [7:0] din;
  logic [9:0]        read_ptr;
  logic              tx_done;
  logic signed [7:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic              m_tlast;
  logic              m_tuser;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;
  int tx_done_cnt = 0;

  logic [9:0] exp_q [$];
  logic [7:0] bram_q;

  always #5 clk = ~clk;

  ofdm_symbol_streamer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .out_buff_full (out_buff_full),
    .din           (din),
    .read_ptr      (read_ptr),
    .tx_done       (tx_done),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tlast       (m_tlast),
    .m_tuser       (m_tuser),
    .busy          (busy)
  );

  // Buffer contents: sample at address a is a[7:0].
  always @(posedge clk) begin
    bram_q <= read_ptr[7:0];
    din    <= bram_q;
  end

  always @(negedge clk) begin
    if (tx_done === 1'b1) tx_done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_read_ptr"}, 32'(read_ptr), 0);
    check({pfx, "_tx_done"}, 32'(tx_done), 0);
    check({pfx, "_tvalid"}, 32'(m_tvalid), 0);
    check({pfx, "_tlast_tuser"}, 32'({m_tlast, m_tuser}), 0);
    check({pfx, "_tdata"}, 32'(m_tdata), 0);
    check({pfx, "_busy"}, 32'(busy), 0);
  endtask

  // mode 0: ready=1, 1: 30% random ready, 2: 50-cycle stall after 10 beats,
  // 3: drop out_buff_full at beat 100, 4: async reset at beat 300.
  task automatic run_burst(input int mode);
    int beats = 0, cyc = 0, first_busy = -1, lat = -1, max_gap = 0;
    int stall = 0, done0;
    logic frozen_ok = 1'b1;
    logic aborted = 1'b0;
    logic [9:0] exp;
    done0 = tx_done_cnt;
    exp_q.delete();
    for (int i = 0; i < TOTAL; i++) begin
      exp_q.push_back({1'(i < 256), 1'(i % 64 == 63), 8'(i)});
    end
    out_buff_full = 1'b1;
    while (beats < TOTAL && cyc < 20000 && !aborted) begin
      @(negedge clk);
      cyc++;
      if (busy && first_busy < 0) first_busy = cyc;
      if (m_tvalid && lat < 0 && first_busy >= 0) lat = cyc - first_busy;
      if (lat >= 0 && (int'(read_ptr) + 1 - beats) > max_gap) max_gap = int'(read_ptr) + 1 - beats;
      m_tready = 1'b1;
      if (mode == 1) m_tready = ($urandom_range(0, 9) < 3);
      if (mode == 2 && beats == 10 && stall < 50) begin
        m_tready = 1'b0;
        stall++;
        if (!(m_tvalid && m_tdata == 8'sd10)) frozen_ok = 1'b0;
        if (stall == 50) begin
          check("stall_tdata", 32'(m_tdata), 10);
          check("stall_read_ptr", 32'(read_ptr), 13);
          check("stall_frozen", 32'(frozen_ok), 1);
        end
      end
      if (mode == 3 && beats >= 100) out_buff_full = 1'b0;
      if (mode == 4 && beats == 300) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        aborted = 1'b1;
      end else if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          check($sformatf("beat%0d", beats), 32'({m_tuser, m_tlast, m_tdata}), 32'(exp));
        end
        beats++;
      end
    end
    m_tready = 1'b1;
    check("first_valid_lat", lat, 4);
    check("max_outstanding_ok", 32'(max_gap <= 4), 1);
    if (aborted) begin
      repeat (3) @(negedge clk);
      check("midrst_busy_held", 32'(busy), 0);
      check("no_done_on_reset", tx_done_cnt - done0, 0);
      rst_n = 1'b1;
    end else begin
      check("beats", beats, TOTAL);
      check("no_early_done", tx_done_cnt - done0, 0);
      repeat (8) @(negedge clk);
      check("done_pulses", tx_done_cnt - done0, 1);
      if (mode == 0) begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          check("wait_clr_busy", 32'(busy), 1);
        end
        check("wait_clr_no_valid", 32'(m_tvalid), 0);
        check("wait_clr_no_redo", tx_done_cnt - done0, 1);
        check("wait_clr_ptr", 32'(read_ptr), 767);
      end
      out_buff_full = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_rst", 32'(busy), 0);
    run_burst(0);
    run_burst(1);
    run_burst(2);
    run_burst(3);
    run_burst(4);
    run_burst(0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ofdm_symbol_streamer.md
Name: ofdm_symbol_streamer

Overview:
- Downstream consumer of the time-synchronizer output buffer.
- Once that buffer reports full, this block reads the CP-stripped burst of 768 samples by driving the buffer's read pointer: 4 channel-estimation symbols followed by 8 data symbols, 64 samples each.
- Samples go out as a valid/ready stream framed per OFDM symbol, for the FFT stage.
- When the burst is fully delivered, it pulses tx_done to release the synchronizer for the next burst.

Parameters:
- SAMPLE_W, 8, sample width (signed).
- ADDR_W, 10, read-pointer width.
- FFT_POINT, 64, samples per symbol.
- NUM_SYM, 12, symbols per burst (total samples = NUM_SYM*FFT_POINT = 768).
- CHEST_SYM, 4, leading symbols tagged as channel-estimation.
- RD_LAT, 3, cycles from read_ptr change to the matching sample on din (addr register + BRAM + dout register).
- FIFO_DEPTH, 4, skid FIFO entries; must be >= RD_LAT+1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- out_buff_full  in  1  upstream buffer holds a complete burst (level)
- din  in  SAMPLE_W  upstream sample, valid RD_LAT cycles after the matching read_ptr
- read_ptr  out  ADDR_W  upstream read address
- tx_done  out  1  one-cycle pulse: burst consumed, upstream may refill
- m_tdata  out  SAMPLE_W  output sample
- m_tvalid  out  1  output valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  last sample of a symbol (index 63)
- m_tuser  out  1  sample belongs to a channel-estimation symbol (symbols 0..CHEST_SYM-1)
- busy  out  1  streaming in progress (state != IDLE)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, read_ptr=0, tx_done=0, m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0, busy=0; FIFO emptied, all counters cleared.
- Reset asserted mid-burst: abort immediately, no tx_done; after release, restart from IDLE.
- State IDLE: wait for out_buff_full=1, then go to STREAM with issue_cnt=0.
- State STREAM, read issue:
  - A read is issued in a cycle when fifo_count + inflight < FIFO_DEPTH.
  - On issue: read_ptr <= issue_cnt and issue_cnt increments.
  - inflight is a RD_LAT-deep valid shift register. Its output marks the cycle din is captured into the FIFO, together with tags (last = issue_cnt[5:0]==63, user = symbol index < CHEST_SYM).
- STREAM to DRAIN when issue_cnt reaches 768 (after address 767 is issued). read_ptr holds 767.
- Credit rule: FIFO never overflows under any m_tready pattern; overflow is a design error (assertion).
- Output: the FIFO head drives m_tdata/m_tlast/m_tuser; m_tvalid = FIFO not empty.
  - Pop on m_tvalid & m_tready.
  - m_tdata/m_tlast/m_tuser stay stable while m_tvalid=1 and m_tready=0.
- State DRAIN: wait until inflight=0 and the FIFO is empty, i.e. the 768th sample has been accepted. Then go to DONE.
- State DONE: tx_done=1 for exactly one cycle, then go to WAIT_CLR.
- State WAIT_CLR: wait for out_buff_full=0, so a stale full level cannot retrigger. Then go to IDLE.
- If out_buff_full drops during STREAM or DRAIN, ignore it and finish the burst.
- Throughput with m_tready held at 1: one sample per cycle after RD_LAT fill. First m_tvalid appears RD_LAT+1 cycles after the entry into STREAM.
- Counters:
  - issue_cnt is ADDR_W+1 bits (holds 768).
  - Symbol index = issue_cnt[ADDR_W-1:6] at issue time.
  - sent_cnt counts accepted samples, used for the DRAIN check and the assertion that sent_cnt=768 at DONE.

Decomposition:
- Shared package ofdm_burst_pkg:
  - FFT_POINT, CP_NUM=16, NUM_DATA_SYM=8, NUM_CHEST_SYM=4, SAMPLES_PER_BURST=768.
  - State enum for IDLE/STREAM/DRAIN/DONE/WAIT_CLR.
  - The synchronizer uses the same package.
- One sub-module: stream_skid_fifo (parameterised width/depth, synchronous FIFO with count output). It stores {tuser, tlast, tdata}.

Test Plan:
- m_tready=1; upstream model returns din=addr[7:0] with RD_LAT=3; assert out_buff_full → 768 beats with tdata 0..255,0..255,0..255. Required: tlast on beats 63,127,…,767; tuser=1 on beats 0..255, 0 on beats 256..767; tx_done single pulse after beat 767; first tvalid 4 cycles after the entry into STREAM.
- m_tready random at 30% duty → identical beat sequence, no loss or duplication; FIFO count never exceeds 4; read_ptr stalls while credits are exhausted.
- m_tready=0 for 50 cycles after 10 beats → m_tdata frozen at value 10; read_ptr stops at 13 (4 entries buffered); resume → beats 10..767 in order.
- After tx_done, hold out_buff_full=1 for 20 cycles → no second burst, busy stays 1 in WAIT_CLR. Drop then reassert → new burst starts at read_ptr=0.
- Pulse rst_n low at beat 300 → all outputs return to reset values asynchronously, no tx_done. Release with out_buff_full=1 → full burst restarts at address 0.
- Drop out_buff_full at beat 100 → burst completes all 768 beats and tx_done still pulses once.
